// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit framing path.
// Ports: none (package only).
// Holds the framer state encoding, preamble/SFD bytes and CRC-32 constants.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG,
    DISCARD
  } eth_state_e;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY_R = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

endpackage

// File: rtl/eth_crc32_d8.sv
// Purpose: one-byte step of the reflected Ethernet CRC-32 (LSB-first bit order).
// Latency: purely combinational; no flow control.
// Ports: crc_i current remainder, data_i next byte, crc_o updated remainder.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/eth_frame_fcs.sv
// Purpose: wraps a header+payload byte stream with preamble/SFD, optional zero pad, CRC-32 FCS and IFG.
// Latency: accepted byte appears on m_axis_tdata one cycle later; output has no backpressure.
// Backpressure: s_axis_tready high only while taking frame data or draining an underrun frame.
// Ports: clk/rst (sync, active-high); s_axis_* frame bytes in (tuser with tlast marks bad frame);
//        m_axis_* wire bytes out (tlast on final FCS byte); underrun pulses when input starves mid-frame.
// Build option: define ETH_FCS_PAD_EN to zero-pad short frames to MIN_FRAME bytes before the FCS.
module eth_frame_fcs
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
`ifdef ETH_FCS_PAD_EN
  parameter int MIN_FRAME    = 60,
`endif
  parameter int IFG_BYTES    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       underrun
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  eth_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d, crc_nxt, fcs_word;
  logic [7:0]  crc_dat;
  logic        bad_q, bad_d;
  logic        drain_q, drain_d;
  logic [7:0]  m_dat_q, m_dat_d;
  logic        m_vld_q, m_vld_d;
  logic        m_last_q, m_last_d;
  logic        underrun_q, underrun_d;

`ifdef ETH_FCS_PAD_EN
  localparam logic [5:0] MIN_L = 6'(MIN_FRAME);
  logic [5:0] byte_cnt_q, byte_cnt_d, bc_inc;
  assign bc_inc = (byte_cnt_q == MIN_L) ? byte_cnt_q : byte_cnt_q + 6'd1;
`endif

  // The drain flag keeps tready up while the FCS and IFG of an underrun frame go out.
  assign s_axis_tready = (state_q == DATA) || (state_q == DISCARD) || drain_q;

  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tlast  = m_last_q;
  assign underrun      = underrun_q;

  // A bad frame sends the raw remainder, i.e. the bitwise inverse of the good FCS.
  assign fcs_word = bad_q ? crc_q : ~crc_q;
  assign crc_dat  = (state_q == PAD) ? 8'h00 : s_axis_tdata;

  eth_crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (crc_dat),
    .crc_o  (crc_nxt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    bad_d      = bad_q;
    drain_d    = drain_q && !(s_axis_tvalid && s_axis_tlast);
    m_dat_d    = 8'h00;
    m_vld_d    = 1'b0;
    m_last_d   = 1'b0;
    underrun_d = 1'b0;
`ifdef ETH_FCS_PAD_EN
    byte_cnt_d = byte_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          state_d = PRE;
          cnt_d   = 8'd0;
        end
      end
      PRE: begin
        m_vld_d = 1'b1;
        m_dat_d = ETH_PREAMBLE;
        if (cnt_q == PRE_LAST) begin
          state_d = SFD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SFD: begin
        m_vld_d = 1'b1;
        m_dat_d = ETH_SFD;
        crc_d   = CRC32_INIT;
        bad_d   = 1'b0;
        state_d = DATA;
`ifdef ETH_FCS_PAD_EN
        byte_cnt_d = 6'd0;
`endif
      end
      DATA: begin
        if (s_axis_tvalid) begin
          m_vld_d = 1'b1;
          m_dat_d = s_axis_tdata;
          crc_d   = crc_nxt;
`ifdef ETH_FCS_PAD_EN
          byte_cnt_d = bc_inc;
`endif
          if (s_axis_tlast) begin
            bad_d = s_axis_tuser;
            cnt_d = 8'd0;
`ifdef ETH_FCS_PAD_EN
            state_d = (bc_inc < MIN_L) ? PAD : FCS;
`else
            state_d = FCS;
`endif
          end
        end else begin
          // Starved: close the frame at once with a poisoned FCS so the wire stream
          // stays gap-free; FCS byte 0 goes out in this slot, the rest of the input frame is drained.
          underrun_d = 1'b1;
          bad_d      = 1'b1;
          drain_d    = 1'b1;
          m_vld_d    = 1'b1;
          m_dat_d    = crc_q[7:0];
          cnt_d      = 8'd1;
          state_d    = FCS;
        end
      end
`ifdef ETH_FCS_PAD_EN
      PAD: begin
        m_vld_d    = 1'b1;
        m_dat_d    = 8'h00;
        crc_d      = crc_nxt;
        byte_cnt_d = bc_inc;
        if (bc_inc == MIN_L) begin
          state_d = FCS;
          cnt_d   = 8'd0;
        end
      end
`endif
      FCS: begin
        m_vld_d = 1'b1;
        m_dat_d = fcs_word[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q[1:0] == 2'd3) begin
          m_last_d = 1'b1;
          state_d  = IFG;
          cnt_d    = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      IFG: begin
        if (cnt_q == IFG_LAST) begin
          cnt_d = 8'd0;
          // A waiting frame goes straight to preamble so the gap is exactly IFG_BYTES.
          if (drain_q)            state_d = drain_d ? DISCARD : IDLE;
          else if (s_axis_tvalid) state_d = PRE;
          else                    state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DISCARD: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      crc_q      <= CRC32_INIT;
      bad_q      <= 1'b0;
      drain_q    <= 1'b0;
      m_dat_q    <= 8'h00;
      m_vld_q    <= 1'b0;
      m_last_q   <= 1'b0;
      underrun_q <= 1'b0;
`ifdef ETH_FCS_PAD_EN
      byte_cnt_q <= 6'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      bad_q      <= bad_d;
      drain_q    <= drain_d;
      m_dat_q    <= m_dat_d;
      m_vld_q    <= m_vld_d;
      m_last_q   <= m_last_d;
      underrun_q <= underrun_d;
`ifdef ETH_FCS_PAD_EN
      byte_cnt_q <= byte_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_eth_frame_fcs.sv
// Directed, table-driven bench for eth_frame_fcs: frames are pushed in, the wire byte
// stream is captured at negedge, and each frame is compared against hand-computed bytes/FCS.
// Works in both builds; with ETH_FCS_PAD_EN the padded FCS comes from a small reference CRC.
module tb_eth_frame_fcs;

  typedef struct packed {
    logic [3:0]      len;
    logic [9:0][7:0] b;
    logic            tuser;
    logic [31:0]     fcs;   // transmitted FCS word, byte 0 in [7:0]
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tlast = 1'b0;
  logic       s_axis_tuser = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       underrun;

  int nchk = 0;
  int nfail = 0;

  logic [7:0] oq[$];
  int         cq[$];
  int         tlidx[$];
  int         und_cnt = 0;
  int         cyc = 0;

  eth_frame_fcs dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .underrun      (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (m_axis_tvalid) begin
      oq.push_back(m_axis_tdata);
      cq.push_back(cyc);
      if (m_axis_tlast) tlidx.push_back(oq.size() - 1);
    end
    if (underrun) und_cnt = und_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string s, input logic tu, input logic [31:0] f);
    vec_t v;
    v = '0;
    v.len = 4'(s.len());
    for (int i = 0; i < s.len(); i++) v.b[i] = s[i];
    v.tuser = tu;
    v.fcs = f;
    return v;
  endfunction

`ifdef ETH_FCS_PAD_EN
  function automatic logic [31:0] model_fcs(input vec_t v);
    logic [31:0] c;
    logic [7:0]  d;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) begin
      d = (i < int'(v.len)) ? v.b[i] : 8'h00;
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ d[k];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return v.tuser ? c : ~c;
  endfunction
`endif

  function automatic logic [31:0] exp_fcs(input vec_t v);
`ifdef ETH_FCS_PAD_EN
    return model_fcs(v);
`else
    return v.fcs;
`endif
  endfunction

  // Drive one frame; optionally drop tvalid for pause_len cycles after pause_at bytes.
  task automatic send(input vec_t v, input int pause_at, input int pause_len, output bit ok);
    int  i;
    int  guard;
    bit  acc;
    i = 0;
    guard = 0;
    ok = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = v.b[0];
    s_axis_tlast  = (v.len == 4'd1);
    s_axis_tuser  = v.tuser;
    while (i < int'(v.len)) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 500) begin
        ok = 1'b0;
        break;
      end
      if (acc) begin
        i++;
        if (i == pause_at) begin
          s_axis_tvalid = 1'b0;
          repeat (pause_len) @(posedge clk);
          #1;
        end
        if (i < int'(v.len)) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = v.b[i];
          s_axis_tlast  = (i == int'(v.len) - 1);
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_tl(input int n, output bit ok);
    int g;
    g = 0;
    while (tlidx.size() < n && g < 400) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    ok = (tlidx.size() >= n);
  endtask

  task automatic check_frame(input string name, input vec_t v, input int plen, input bit pad,
                             input int start, input int tl_ord, input logic [31:0] fcs_e,
                             input int und_e, input int und0);
    logic [7:0]  exp[$];
    int          got_len;
    int          mism;
    int          e;
    logic [31:0] fcs_g;
    for (int i = 0; i < 7; i++) exp.push_back(8'h55);
    exp.push_back(8'hD5);
    for (int i = 0; i < plen; i++) exp.push_back(v.b[i]);
`ifdef ETH_FCS_PAD_EN
    if (pad) while (exp.size() < 68) exp.push_back(8'h00);
`else
    if (pad) mism = 0;
`endif
    e = exp.size();
    got_len = (tlidx.size() > tl_ord) ? tlidx[tl_ord] - start + 1 : -1;
    chk({name, "_len"}, 32'(got_len), 32'(e + 4));
    mism = 0;
    for (int i = 0; i < e; i++)
      if (start + i >= oq.size() || oq[start + i] !== exp[i]) mism++;
    chk({name, "_bytes_bad"}, 32'(mism), 32'd0);
    fcs_g = 32'hxxxxxxxx;
    if (start + e + 3 < oq.size())
      fcs_g = {oq[start + e + 3], oq[start + e + 2], oq[start + e + 1], oq[start + e]};
    chk({name, "_fcs"}, fcs_g, fcs_e);
    if (start + e + 3 < cq.size())
      chk({name, "_span"}, 32'(cq[start + e + 3] - cq[start]), 32'(e + 3));
    else
      chk({name, "_span"}, 32'hFFFFFFFF, 32'(e + 3));
    chk({name, "_underruns"}, 32'(und_cnt - und0), 32'(und_e));
  endtask

  initial begin
    vec_t vt [5];
    vec_t v;
    vec_t vu;
    bit   ok;
    int   st, t0, u0, stb, nacc, g;
    bit   a;

    vt[0] = mk("123456789", 1'b0, 32'hCBF43926);
    vt[1] = mk("123456789", 1'b1, 32'h340BC6D9);
    vt[2] = mk("abc",       1'b0, 32'h352441C2);
    vt[3] = mk("0",         1'b0, 32'hD202EF8D);
    vt[3].b[0] = 8'h00;
    vt[4] = mk("a",         1'b1, 32'h174841BC);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata",    32'(m_axis_tdata),  32'd0);
    chk("rst_tlast",    32'(m_axis_tlast),  32'd0);
    chk("rst_underrun", 32'(underrun),      32'd0);
    chk("rst_tready",   32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // table-driven single frames
    for (int vi = 0; vi < 5; vi++) begin
      v = vt[vi];
      st = oq.size();
      t0 = tlidx.size();
      u0 = und_cnt;
      send(v, 0, 0, ok);
      chk($sformatf("v%0d_send", vi), 32'(ok), 32'd1);
      wait_tl(t0 + 1, ok);
      chk($sformatf("v%0d_done", vi), 32'(ok), 32'd1);
      repeat (16) @(posedge clk);
      #1;
      check_frame($sformatf("v%0d", vi), v, int'(v.len), 1'b1, st, t0, exp_fcs(v), 0, u0);
    end

    // underrun after 3 of 10 bytes: poisoned FCS of "abc", rest drained
    vu = mk("abcdefghij", 1'b0, 32'h0);
    st = oq.size();
    t0 = tlidx.size();
    u0 = und_cnt;
    send(vu, 3, 3, ok);
    chk("und_drain", 32'(ok), 32'd1);
    wait_tl(t0 + 1, ok);
    repeat (20) @(posedge clk);
    #1;
    check_frame("und", vu, 3, 1'b0, st, t0, 32'hCADBBE3D, 1, u0);
    @(negedge clk);
    chk("und_idle_tready", 32'(s_axis_tready), 32'd0);
    @(posedge clk);
    #1;

    // back-to-back frames: second one held off through FCS and IFG
    st = oq.size();
    t0 = tlidx.size();
    u0 = und_cnt;
    send(vt[0], 0, 0, ok);
    send(vt[0], 0, 0, ok);
    chk("b2b_send", 32'(ok), 32'd1);
    wait_tl(t0 + 2, ok);
    repeat (16) @(posedge clk);
    #1;
    check_frame("b2b_a", vt[0], 9, 1'b1, st, t0, exp_fcs(vt[0]), 0, u0);
    stb = (tlidx.size() > t0) ? tlidx[t0] + 1 : st;
    check_frame("b2b_b", vt[0], 9, 1'b1, stb, t0 + 1, exp_fcs(vt[0]), 0, u0);
    if (stb < cq.size() && stb > 0)
      chk("b2b_gap", 32'(cq[stb] - cq[stb - 1]), 32'd13);
    else
      chk("b2b_gap", 32'hFFFFFFFF, 32'd13);

    // reset while in DATA truncates the frame; next frame is clean
    t0 = tlidx.size();
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = vt[0].b[0];
    nacc = 0;
    g = 0;
    while (nacc < 3 && g < 100) begin
      @(negedge clk);
      a = s_axis_tready;
      @(posedge clk);
      #1;
      g++;
      if (a) begin
        nacc++;
        s_axis_tdata = vt[0].b[nacc];
      end
    end
    chk("rst6_accepts", 32'(nacc), 32'd3);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst6_tvalid", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst6_no_fcs", 32'(tlidx.size()), 32'(t0));
    st = oq.size();
    u0 = und_cnt;
    send(vt[0], 0, 0, ok);
    wait_tl(t0 + 1, ok);
    chk("rst6_done", 32'(ok), 32'd1);
    repeat (16) @(posedge clk);
    #1;
    check_frame("rst6", vt[0], 9, 1'b1, st, t0, exp_fcs(vt[0]), 0, u0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
